obi_pattern_matcher: RTL and testbench
======================================

// Module: obi_pattern_matcher
//
// PURPOSE
//  Compute engine driven by the simple MMIO block's start/done/match bits.
//  A rising edge on start_i makes it read NumWords 32-bit words through an OBI
//  manager port, one word at a time, from BaseAddr upward.
//  Each word is compared (under CmpMask) against a fixed expected pattern.
//  When the compare finishes it reports done_o and match_o back to the MMIO block.
//
// PARAMETERS
//  NumWords   default 4              number of words compared; legal range 1..256
//  BaseAddr   default 32'h1000_0000  byte address of word 0; must be word-aligned
//  Pattern    default '0             logic [NumWords-1:0][31:0]; word i is the expected value at BaseAddr+4*i
//  CmpMask    default 32'hFFFF_FFFF  bits compared in every word; bits at 0 are ignored
//
// PORTS
//  clk_i      in   1   clock
//  rst_ni     in   1   reset: asynchronous, active-low
//  start_i    in   1   level input from MMIO start_o; only a rising edge has effect
//  done_o     out  1   compare finished; sticky until the next accepted start
//  match_o    out  1   all words matched; valid only while done_o=1
//  req_o      out  1   OBI A-channel request
//  gnt_i      in   1   OBI grant
//  addr_o     out  32  OBI byte address
//  we_o       out  1   tied 0 (read only)
//  be_o       out  4   tied 4'hF
//  rvalid_i   in   1   OBI R-channel valid
//  rdata_i    in   32  OBI read data
//  err_i      in   1   OBI error, sampled together with rvalid_i
//
// BEHAVIOUR
//  Reset values: done_o=0, match_o=0, req_o=0, addr_o=BaseAddr, FSM=IDLE, idx=0, start_q=0.
//  Start detection
//   - start_q is a registered copy of start_i.
//   - Accepted edge = start_i & ~start_q, and only when the FSM is IDLE or DONE.
//   - An edge arriving in REQ or WAIT is ignored and is not queued.
//  FSM states
//   - IDLE: wait for an accepted edge; then idx=0, done_o=0, match_o=0, go to REQ.
//   - REQ: req_o=1, addr_o=BaseAddr+4*idx. Hold req_o and addr_o stable until gnt_i.
//     When req_o & gnt_i, go to WAIT.
//   - WAIT: req_o=0. Exactly one transaction is outstanding. On rvalid_i:
//     - err_i=1: match_o=0, go to DONE.
//     - ((rdata_i ^ Pattern[idx]) & CmpMask) != 0: match_o=0, go to DONE (early exit on mismatch).
//     - idx==NumWords-1: match_o=1, go to DONE.
//     - otherwise: idx++, go to REQ.
//   - DONE: done_o=1, match_o holds its value. An accepted edge clears done_o and match_o
//     and goes to REQ (equivalent to IDLE -> REQ).
//  Timing
//   - done_o and match_o are registered and rise 1 cycle after the final rvalid_i.
//   - With zero-wait gnt_i and rvalid_i one cycle after grant, a full match takes
//     2*NumWords+1 cycles from the start edge to done_o=1.
//  Arithmetic
//   - idx is $clog2(NumWords+1) bits.
//   - Address is computed modulo 2^32; wrap past 32'hFFFF_FFFC is allowed and not flagged.
//  Boundary conditions
//   - rvalid_i outside WAIT is ignored.
//   - start_i held high for many cycles counts as a single edge.
//   - The MMIO block rewriting start=1 while start_i is already 1 gives no new edge.
//     Software must write 0 and then 1.
//   - Reset mid-operation immediately returns to the reset state and drops req_o.
//     Any late rvalid_i after reset is ignored.
//
// STRUCTURE
//  user_pkg holds:
//   - typedef pm_state_e {IDLE, REQ, WAIT, DONE}
//   - localparam PmWordBytes = 4
//  These OBI fields map onto mgr_obi_req_t / mgr_obi_rsp_t at the top level.
//  Single flat module; no sub-module.
//
// TESTING
//  1. NumWords=4, memory equals Pattern, zero-wait -> done_o=1 and match_o=1 at cycle 9
//     after the edge; addresses 0x1000_0000..0x1000_000C, each read once.
//  2. Word 1 differs in bit 5, CmpMask=all ones -> match_o=0, done_o=1,
//     only 2 requests issued (early exit).
//  3. Same data with CmpMask=32'hFFFF_FFDF -> match_o=1 after 4 reads.
//  4. gnt_i delayed 3 cycles and rvalid_i delayed 5 cycles -> req_o and addr_o stable
//     until grant, result unchanged; a second start edge during WAIT is ignored.
//  5. err_i=1 on word 2 -> done_o=1, match_o=0, no further requests;
//     toggling start_i 0->1 reruns and clears done_o for the run.
//  6. rst_ni asserted during WAIT -> all outputs at reset values;
//     a stale rvalid_i after release causes no state change.

Source files
------------

// File: rtl/obi_pattern_matcher_pkg.sv
// Shared types for the OBI pattern matcher.
//   pm_state_e     : controller states
//   PmWordBytes    : byte stride between consecutive words
//   mgr_obi_req_t  : manager-driven OBI fields (A channel)
//   mgr_obi_rsp_t  : subordinate-driven OBI fields (grant + R channel)
package obi_pattern_matcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } pm_state_e;

  localparam int unsigned PmWordBytes = 4;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
  } mgr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/obi_pattern_matcher_if.sv
// OBI manager bus bundle used by the pattern matcher.
//   req : manager -> subordinate (req, addr, we, be)
//   rsp : subordinate -> manager (gnt, rvalid, rdata, err)
// Modports: master (the matcher), slave (memory / responder).
interface obi_pattern_matcher_if;
  import obi_pattern_matcher_pkg::*;

  mgr_obi_req_t req;
  mgr_obi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/obi_pattern_matcher.sv
// Reads NumWords words over OBI starting at BaseAddr after a rising edge on
// start_i, compares each (under CmpMask) with Pattern and reports done/match.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : level from MMIO; a rising edge in IDLE/DONE starts a compare
//   done_o   : compare finished, sticky until the next accepted start
//   match_o  : all words matched, meaningful while done_o=1
//   obi      : OBI manager port (one outstanding read at a time)
module obi_pattern_matcher
  import obi_pattern_matcher_pkg::*;
#(
  parameter int unsigned                NumWords = 4,
  parameter logic [31:0]                BaseAddr = 32'h1000_0000,
  parameter logic [NumWords-1:0][31:0]  Pattern  = '0,
  parameter logic [31:0]                CmpMask  = 32'hFFFF_FFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    done_o,
  output logic                    match_o,
  obi_pattern_matcher_if.master   obi
);

  localparam int unsigned IdxW = $clog2(NumWords + 1);

  pm_state_e       state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            start_q;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            match_q, match_d;

  logic [31:0]     exp_word;
  logic            start_edge;
  logic            word_ok;
  logic            last_word;

  // Select the expected word by comparing against every index, which keeps
  // the select legal for any NumWords without an out-of-range index.
  always_comb begin
    exp_word = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      if (idx_q == IdxW'(i)) exp_word = Pattern[i];
    end
  end

  // Edges seen while a read is in flight are dropped, not queued.
  assign start_edge = start_i & ~start_q & ((state_q == IDLE) || (state_q == DONE));
  assign word_ok    = ~obi.rsp.err && (((obi.rsp.rdata ^ exp_word) & CmpMask) == '0);
  assign last_word  = (idx_q == IdxW'(NumWords - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    done_d  = done_q;
    match_d = match_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          idx_d   = '0;
          done_d  = 1'b0;
          match_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (obi.rsp.gnt) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (obi.rsp.rvalid) begin
          if (!word_ok) begin
            // Error or mismatch: stop early without reading further words.
            match_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (last_word) begin
            match_d = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_i;
      req_q   <= req_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  // Address derives from idx, so it is stable for the whole REQ phase and
  // wraps naturally modulo 2^32.
  assign obi.req.req  = req_q;
  assign obi.req.addr = BaseAddr + (32'(idx_q) * 32'(PmWordBytes));
  assign obi.req.we   = 1'b0;
  assign obi.req.be   = 4'hF;

  assign done_o  = done_q;
  assign match_o = match_q;

endmodule

// File: tb/tb_obi_pattern_matcher.sv
// Bench for obi_pattern_matcher: two instances (full mask and a mask that
// ignores bit 5) run side by side against a memory responder; results are
// compared with a word-by-word reference model of the compare rules.
module tb_obi_pattern_matcher;

  localparam logic [31:0]       BASE = 32'h1000_0000;
  localparam logic [3:0][31:0]  PAT  = {32'hCAFE_0003, 32'h1234_5602,
                                        32'hA5A5_0001, 32'hDEAD_BEE0};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic [1:0] done_w, match_w, req_w;
  logic [31:0] addr_w [2];

  int checks = 0;
  int errors = 0;

  // Responder configuration shared by both instances.
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          err_word  = -1;
  logic [31:0] mem [4];
  int          nreq [2];
  logic [31:0] alog [2][16];

  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input int g);
    return (g == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFDF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    obi_pattern_matcher_if bus ();

    obi_pattern_matcher #(
      .NumWords (4),
      .BaseAddr (BASE),
      .Pattern  (PAT),
      .CmpMask  ((g == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFDF)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .done_o  (done_w[g]),
      .match_o (match_w[g]),
      .obi     (bus)
    );

    assign req_w[g]  = bus.req.req;
    assign addr_w[g] = bus.req.addr;

    // Memory responder: drives at negedge, grant after gnt_delay cycles of
    // request, read data rv_delay cycles after the accepting edge.
    initial begin
      int          gwait;
      bit          acc;
      bit          rv_act;
      int          rv_cnt;
      int          rv_word;
      logic [31:0] acc_addr;
      bit          holding;
      logic [31:0] hold_addr;
      gwait = 0; acc = 0; rv_act = 0; rv_cnt = 0; rv_word = 0;
      acc_addr = '0; holding = 0; hold_addr = '0;
      bus.rsp = '0;
      forever begin
        @(negedge clk);
        if (acc) begin
          if (nreq[g] < 16) alog[g][nreq[g]] = acc_addr;
          nreq[g]++;
          rv_act  = 1;
          rv_cnt  = rv_delay;
          rv_word = int'((acc_addr - BASE) >> 2);
          acc     = 0;
        end
        bus.rsp.gnt    = 1'b0;
        bus.rsp.rvalid = 1'b0;
        bus.rsp.err    = 1'b0;
        bus.rsp.rdata  = $urandom();
        if (rv_act) begin
          if (rv_cnt == 0) begin
            bus.rsp.rvalid = 1'b1;
            if (rv_word >= 0 && rv_word < 4) bus.rsp.rdata = mem[rv_word];
            bus.rsp.err = (rv_word == err_word);
            rv_act = 0;
          end else begin
            rv_cnt--;
          end
        end
        if (holding) begin
          checks++;
          assert (bus.req.req === 1'b1 && bus.req.addr === hold_addr) else begin
            errors++;
            $error("FAIL req_hold dut%0d: observed req=%b addr=%h expected req=1 addr=%h",
                   g, bus.req.req, bus.req.addr, hold_addr);
          end
        end
        holding = 0;
        if (bus.req.req) begin
          if (gwait >= gnt_delay) begin
            bus.rsp.gnt = 1'b1;
            acc      = 1;
            acc_addr = bus.req.addr;
            gwait    = 0;
          end else begin
            gwait++;
            holding   = 1;
            hold_addr = bus.req.addr;
          end
        end else begin
          gwait = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: walk words in order; an error or a masked difference ends
  // the compare with no match after that read; otherwise all words match.
  task automatic model(input logic [31:0] mask, output bit m, output int reads);
    bit stop;
    stop = 0;
    m = 1;
    reads = 4;
    for (int i = 0; i < 4; i++) begin
      if (!stop && (i == err_word || ((mem[i] ^ PAT[i]) & mask) != 0)) begin
        m = 0;
        reads = i + 1;
        stop = 1;
      end
    end
  endtask

  task automatic do_run(input string tag, input bit check_lat, input bit toggle_mid);
    bit m_exp [2];
    int r_exp [2];
    bit fin   [2];
    int lat   [2];
    int cyc;
    int tstage;
    for (int g = 0; g < 2; g++) begin
      nreq[g] = 0;
      model(mask_of(g), m_exp[g], r_exp[g]);
      fin[g] = 0;
      lat[g] = 0;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    cyc = 0;
    tstage = 0;
    while (!(fin[0] && fin[1]) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        for (int g = 0; g < 2; g++) chk({tag, "_done_clr"}, 32'(done_w[g]), 32'd0);
      end
      if (toggle_mid) begin
        case (tstage)
          0: if (req_w[0]) tstage = 1;
          1: if (!req_w[0]) begin start_i = 1'b0; tstage = 2; end
          2: begin start_i = 1'b1; tstage = 3; end
          default: ;
        endcase
      end
      for (int g = 0; g < 2; g++) begin
        if (!fin[g] && done_w[g]) begin
          fin[g] = 1;
          lat[g] = cyc;
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_finished_dut%0d", tag, g), 32'(fin[g]), 32'd1);
      chk($sformatf("%s_match_dut%0d", tag, g), 32'(match_w[g]), 32'(m_exp[g]));
      if (check_lat)
        chk($sformatf("%s_latency_dut%0d", tag, g), 32'(lat[g]), 32'(2 * r_exp[g] + 1));
    end
    // No rerun and no extra requests while start_i stays high.
    repeat (4) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("%s_idle_req_dut%0d", tag, g), 32'(req_w[g]), 32'd0);
        chk($sformatf("%s_idle_done_dut%0d", tag, g), 32'(done_w[g]), 32'd1);
      end
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_nreq_dut%0d", tag, g), 32'(nreq[g]), 32'(r_exp[g]));
      for (int i = 0; i < r_exp[g] && i < 16; i++)
        chk($sformatf("%s_addr%0d_dut%0d", tag, i, g), alog[g][i], BASE + 32'(4 * i));
    end
  endtask

  initial begin
    int w;
    int b;
    int cnt;
    for (int i = 0; i < 4; i++) mem[i] = PAT[i];
    nreq[0] = 0;
    nreq[1] = 0;

    // Reset state.
    #12;
    for (int g = 0; g < 2; g++) begin
      chk("rst_done",  32'(done_w[g]),  32'd0);
      chk("rst_match", 32'(match_w[g]), 32'd0);
      chk("rst_req",   32'(req_w[g]),   32'd0);
      chk("rst_addr",  addr_w[g],       BASE);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Full match, zero wait.
    do_run("t1_match", 1, 0);

    // Word 1 differs in bit 5: full mask exits early, masked instance matches.
    mem[1] = PAT[1] ^ 32'h0000_0020;
    do_run("t2_bit5", 1, 0);
    mem[1] = PAT[1];

    // Slow grant and read data, extra start edge during WAIT.
    gnt_delay = 3;
    rv_delay  = 5;
    do_run("t4_slow", 0, 1);

    // Bus error on word 2, then a clean rerun.
    gnt_delay = 0;
    rv_delay  = 0;
    err_word  = 2;
    do_run("t5_err", 1, 0);
    err_word  = -1;
    do_run("t5_rerun", 1, 0);

    // Reset while a read is outstanding; the late rvalid must be ignored.
    rv_delay = 5;
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    cnt = 0;
    while (!req_w[0] && cnt < 20) begin @(posedge clk); #1; cnt++; end
    while (req_w[0] && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("t6_reached_wait", 32'(cnt < 40), 32'd1);
    rst_ni  = 1'b0;
    start_i = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("t6_rst_done",  32'(done_w[g]),  32'd0);
      chk("t6_rst_match", 32'(match_w[g]), 32'd0);
      chk("t6_rst_req",   32'(req_w[g]),   32'd0);
      chk("t6_rst_addr",  addr_w[g],       BASE);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        chk("t6_stale_req",   32'(req_w[g]),   32'd0);
        chk("t6_stale_done",  32'(done_w[g]),  32'd0);
        chk("t6_stale_match", 32'(match_w[g]), 32'd0);
      end
    end

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) mem[i] = PAT[i];
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, 3);
        b = ($urandom_range(0, 2) == 0) ? 5 : $urandom_range(0, 31);
        mem[w] = mem[w] ^ (32'd1 << b);
      end
      err_word  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(0, 3);
      do_run($sformatf("rnd%0d", r), (gnt_delay == 0 && rv_delay == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
